// File: rtl/ds_operand_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds_operand_unit_pkg : shared widths and bypass source indices for DS stage
// Rev 1.0
// ---------------------------------------------------------------------------
package ds_operand_unit_pkg;

  localparam int DS_DATA_W       = 32;
  localparam int DS_REG_AW       = 5;
  localparam int FS_TO_DS_BUS_WD = 64;

  // Bypass source order: lower index is younger and wins on a tie.
  localparam int SRC_ES = 0;
  localparam int SRC_MS = 1;
  localparam int SRC_WS = 2;

endpackage
`default_nettype wire

// File: rtl/ds_fwd_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds_fwd_mux : single read port priority bypass match and operand select
// Rev 1.0
// ---------------------------------------------------------------------------
module ds_fwd_mux
  import ds_operand_unit_pkg::*;
#(
  parameter int DATA_W  = DS_DATA_W,
  parameter int REG_AW  = DS_REG_AW,
  parameter int NUM_SRC = 3
) (
  input  logic [REG_AW-1:0]         rd_addr,
  input  logic                      rd_used,
  input  logic [DATA_W-1:0]         rf_rdata,
  input  logic [NUM_SRC-1:0]        fwd_valid,
  input  logic [NUM_SRC*REG_AW-1:0] fwd_dest,
  input  logic [NUM_SRC-1:0]        fwd_ready,
  input  logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         opnd_value,
  output logic                      opnd_hazard
);

  logic found;

  always_comb begin
    opnd_value  = rf_rdata;
    opnd_hazard = 1'b0;
    found       = 1'b0;
    // Only the youngest matching source is considered; an unready winner
    // blocks even if an older source holds the same register.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && rd_used && (rd_addr != '0) && fwd_valid[i] &&
          (fwd_dest[i*REG_AW +: REG_AW] == rd_addr)) begin
        found       = 1'b1;
        opnd_value  = fwd_data[i*DATA_W +: DATA_W];
        opnd_hazard = ~fwd_ready[i];
      end
    end
    if (rd_addr == '0) begin
      opnd_value = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ds_operand_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds_operand_unit : DS pipeline register, operand bypass, stall counter, watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module ds_operand_unit
  import ds_operand_unit_pkg::*;
#(
  parameter int DATA_W    = DS_DATA_W,
  parameter int REG_AW    = DS_REG_AW,
  parameter int NUM_RD    = 2,
  parameter int NUM_SRC   = 3,
  parameter int PAYLOAD_W = FS_TO_DS_BUS_WD,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      fs_to_ds_valid,
  input  logic [PAYLOAD_W-1:0]      fs_to_ds_bus,
  output logic                      ds_allowin,
  input  logic                      es_allowin,
  output logic                      ds_to_es_valid,
  output logic [PAYLOAD_W-1:0]      ds_payload,
  input  logic [NUM_RD*REG_AW-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_used,
  input  logic [NUM_RD*DATA_W-1:0]  rf_rdata,
  input  logic [NUM_SRC-1:0]        fwd_valid,
  input  logic [NUM_SRC*REG_AW-1:0] fwd_dest,
  input  logic [NUM_SRC-1:0]        fwd_ready,
  input  logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*DATA_W-1:0]  opnd_value,
  output logic [NUM_RD-1:0]         opnd_hazard,
  output logic                      ds_stall,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      stall_timeout
);

  localparam int                 CONS_W   = $clog2(MAX_STALL + 1);
  localparam logic [CONS_W-1:0]  CONS_MAX = CONS_W'(MAX_STALL);

  logic                 ds_valid_q, ds_valid_d;
  logic [PAYLOAD_W-1:0] ds_payload_q, ds_payload_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [CONS_W-1:0]    consec_q, consec_d;
  logic                 stall_timeout_q, stall_timeout_d;
  logic                 ready_go;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    ds_fwd_mux #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_SRC (NUM_SRC)
    ) u_fwd_mux (
      .rd_addr     (rd_addr[p*REG_AW +: REG_AW]),
      .rd_used     (rd_used[p]),
      .rf_rdata    (rf_rdata[p*DATA_W +: DATA_W]),
      .fwd_valid   (fwd_valid),
      .fwd_dest    (fwd_dest),
      .fwd_ready   (fwd_ready),
      .fwd_data    (fwd_data),
      .opnd_value  (opnd_value[p*DATA_W +: DATA_W]),
      .opnd_hazard (opnd_hazard[p])
    );
  end

  assign ready_go       = ~|opnd_hazard;
  assign ds_allowin     = !ds_valid_q || (ready_go && es_allowin);
  // Flush is deliberately not applied here; downstream kills in the same cycle.
  assign ds_to_es_valid = ds_valid_q && ready_go;
  assign ds_stall       = ds_valid_q && !ready_go;
  assign ds_payload     = ds_payload_q;
  assign stall_cycles   = stall_cycles_q;
  assign stall_timeout  = stall_timeout_q;

  always_comb begin
    ds_valid_d      = ds_valid_q;
    ds_payload_d    = ds_payload_q;
    stall_cycles_d  = stall_cycles_q;
    consec_d        = '0;
    stall_timeout_d = stall_timeout_q;

    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
    end

    if (fs_to_ds_valid && ds_allowin && !flush) begin
      ds_payload_d = fs_to_ds_bus;
    end

    if (ds_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    if (ds_stall && !flush) begin
      consec_d = (consec_q == CONS_MAX) ? consec_q : consec_q + CONS_W'(1);
    end

    if (consec_d == CONS_MAX) begin
      stall_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q      <= 1'b0;
      ds_payload_q    <= '0;
      stall_cycles_q  <= '0;
      consec_q        <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      ds_valid_q      <= ds_valid_d;
      ds_payload_q    <= ds_payload_d;
      stall_cycles_q  <= stall_cycles_d;
      consec_q        <= consec_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds_operand_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ds_operand_unit : scoreboard bench with directed and random stimulus
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ds_operand_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NS = 3;
  localparam int PW = 64;
  localparam int CW = 32;
  localparam int MS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Live stimulus
  logic          s_reset = 1'b1;
  logic          s_flush = 1'b0;
  logic          s_fsv   = 1'b0;
  logic [PW-1:0] s_bus   = '0;
  logic          s_esa   = 1'b1;
  logic [AW-1:0] s_addr [NR];
  logic          s_used [NR];
  logic [DW-1:0] s_rf   [NR];
  logic          s_fv   [NS];
  logic [AW-1:0] s_fd   [NS];
  logic          s_fr   [NS];
  logic [DW-1:0] s_fdat [NS];

  logic [NR*AW-1:0] w_rd_addr;
  logic [NR-1:0]    w_rd_used;
  logic [NR*DW-1:0] w_rf_rdata;
  logic [NS-1:0]    w_fwd_valid, w_fwd_ready;
  logic [NS*AW-1:0] w_fwd_dest;
  logic [NS*DW-1:0] w_fwd_data;

  always_comb begin
    for (int p = 0; p < NR; p++) begin
      w_rd_addr[p*AW +: AW]  = s_addr[p];
      w_rd_used[p]           = s_used[p];
      w_rf_rdata[p*DW +: DW] = s_rf[p];
    end
    for (int i = 0; i < NS; i++) begin
      w_fwd_valid[i]          = s_fv[i];
      w_fwd_dest[i*AW +: AW]  = s_fd[i];
      w_fwd_ready[i]          = s_fr[i];
      w_fwd_data[i*DW +: DW]  = s_fdat[i];
    end
  end

  logic          ds_allowin, ds_to_es_valid, ds_stall, stall_timeout;
  logic [PW-1:0] ds_payload;
  logic [NR*DW-1:0] opnd_value;
  logic [NR-1:0] opnd_hazard;
  logic [CW-1:0] stall_cycles;

  ds_operand_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .NUM_SRC(NS),
    .PAYLOAD_W(PW), .CNT_W(CW), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .fs_to_ds_valid(s_fsv), .fs_to_ds_bus(s_bus),
    .ds_allowin(ds_allowin), .es_allowin(s_esa),
    .ds_to_es_valid(ds_to_es_valid), .ds_payload(ds_payload),
    .rd_addr(w_rd_addr), .rd_used(w_rd_used), .rf_rdata(w_rf_rdata),
    .fwd_valid(w_fwd_valid), .fwd_dest(w_fwd_dest),
    .fwd_ready(w_fwd_ready), .fwd_data(w_fwd_data),
    .opnd_value(opnd_value), .opnd_hazard(opnd_hazard),
    .ds_stall(ds_stall), .stall_cycles(stall_cycles),
    .stall_timeout(stall_timeout)
  );

  // Reference model state
  logic          m_valid = 1'b0;
  logic [PW-1:0] m_payload = '0;
  int unsigned   m_stalls = 0;
  int            m_consec = 0;
  logic          m_timeout = 1'b0;

  typedef struct {
    logic          allowin;
    logic          to_es;
    logic          stall;
    logic [PW-1:0] payload;
    logic [CW-1:0] stalls;
    logic          timeout;
    logic          hz [NR];
    logic [DW-1:0] val [NR];
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Youngest source naming the register decides; register 0 is always zero.
  function automatic void resolve(input int p, output logic [DW-1:0] v, output logic hz);
    v  = s_rf[p];
    hz = 1'b0;
    if (s_addr[p] == 0) begin
      v = '0;
      return;
    end
    if (!s_used[p]) return;
    for (int i = 0; i < NS; i++) begin
      if (s_fv[i] && s_fd[i] == s_addr[p]) begin
        v  = s_fdat[i];
        hz = !s_fr[i];
        return;
      end
    end
  endfunction

  task automatic step();
    exp_t e;
    logic any_hz;
    logic nv, nt;
    logic [PW-1:0] np;
    int unsigned ns;
    int nc;
    any_hz = 1'b0;
    for (int p = 0; p < NR; p++) begin
      resolve(p, e.val[p], e.hz[p]);
      any_hz = any_hz | e.hz[p];
    end
    e.allowin = !m_valid || (!any_hz && s_esa);
    e.to_es   = m_valid && !any_hz;
    e.stall   = m_valid && any_hz;
    e.payload = m_payload;
    e.stalls  = CW'(m_stalls);
    e.timeout = m_timeout;
    sb.push_back(e);

    nv = s_flush ? 1'b0 : (e.allowin ? s_fsv : m_valid);
    np = (s_fsv && e.allowin && !s_flush) ? s_bus : m_payload;
    ns = (e.stall && m_stalls != 32'hFFFF_FFFF) ? m_stalls + 1 : m_stalls;
    nc = (e.stall && !s_flush) ? ((m_consec + 1 > MS) ? MS : m_consec + 1) : 0;
    nt = m_timeout || (nc == MS);
    @(posedge clk);
    if (s_reset) begin
      m_valid = 0; m_payload = '0; m_stalls = 0; m_consec = 0; m_timeout = 0;
    end else begin
      m_valid = nv; m_payload = np; m_stalls = ns; m_consec = nc; m_timeout = nt;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ds_allowin", 64'(ds_allowin), 64'(e.allowin));
      chk("ds_to_es_valid", 64'(ds_to_es_valid), 64'(e.to_es));
      chk("ds_stall", 64'(ds_stall), 64'(e.stall));
      chk("ds_payload", ds_payload, e.payload);
      chk("stall_cycles", 64'(stall_cycles), 64'(e.stalls));
      chk("stall_timeout", 64'(stall_timeout), 64'(e.timeout));
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("opnd_hazard%0d", p), 64'(opnd_hazard[p]), 64'(e.hz[p]));
        if (!e.hz[p])
          chk($sformatf("opnd_value%0d", p), 64'(opnd_value[p*DW +: DW]), 64'(e.val[p]));
      end
    end
  end

  task automatic quiet();
    s_reset = 0; s_flush = 0; s_fsv = 0; s_esa = 1;
    for (int p = 0; p < NR; p++) begin
      s_addr[p] = '0; s_used[p] = 0; s_rf[p] = 32'h1000_0000 + p;
    end
    for (int i = 0; i < NS; i++) begin
      s_fv[i] = 0; s_fd[i] = '0; s_fr[i] = 1; s_fdat[i] = '0;
    end
  endtask

  // Source i writes register d with readiness r and data v.
  task automatic src(input int i, input logic [AW-1:0] d, input logic r, input logic [DW-1:0] v);
    s_fv[i] = 1; s_fd[i] = d; s_fr[i] = r; s_fdat[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    quiet();
    s_reset = 1;
    @(posedge clk); #1;
    step();                                   // reset state
    s_reset = 0;

    // Load an instruction, then bypass priority: ES beats MS
    s_fsv = 1; s_bus = 64'h0000_0001_BFC0_0000;
    step();
    s_fsv = 0;
    s_addr[0] = 5; s_used[0] = 1; s_rf[0] = 32'h5555;
    src(0, 5, 1, 32'hAAAA); src(1, 5, 1, 32'hBBBB);
    step();

    // Unready youngest winner blocks even though MS is ready
    s_fv[0] = 1; s_fr[0] = 0;
    s_fsv = 1; s_bus = 64'hDEAD_BEEF_0000_0004;
    step(); step();
    s_fr[0] = 1;                              // resolves: leaves this cycle
    step();

    // Register zero and unused ports never hazard
    s_fsv = 1; s_bus = 64'h0000_0002_BFC0_0008;
    s_addr[0] = 0; src(0, 0, 0, 32'h1234);
    s_addr[1] = 7; s_used[1] = 0; src(2, 7, 0, 32'h7777);
    step(); step();

    // Watchdog: hold hazard for MAX_STALL cycles, then clear
    quiet();
    s_addr[1] = 9; s_used[1] = 1; src(1, 9, 0, 32'h9999);
    repeat (MS + 1) step();
    s_fr[1] = 1;
    step(); step();

    // Stall and flush together with a new fetch
    s_fsv = 1; s_bus = 64'h1111_2222_3333_4444;
    step();
    s_fr[1] = 0; s_fsv = 1; s_bus = 64'h5555_6666_7777_8888;
    step(); step();
    s_flush = 1;
    step();
    s_flush = 0; s_fsv = 0;
    step();

    // Reset in the middle of a stall
    s_fsv = 1; s_bus = 64'hABCD_0000_0000_0010;
    step(); step();
    s_reset = 1;
    step();
    s_reset = 0; s_fsv = 0;
    step();

    // Backpressure without hazard, then release
    quiet();
    s_fsv = 1; s_bus = 64'h0000_0003_0000_0020;
    step();
    s_esa = 0; s_bus = 64'h0000_0004_0000_0024;
    step(); step();
    s_esa = 1;
    step(); step();

    // Randomized traffic on a small register space to provoke matches
    for (int n = 0; n < 600; n++) begin
      s_reset = ($urandom_range(0, 199) == 0);
      s_flush = ($urandom_range(0, 29) == 0);
      s_fsv   = ($urandom_range(0, 9) < 7);
      s_bus   = {$urandom, $urandom};
      s_esa   = ($urandom_range(0, 9) < 8);
      for (int p = 0; p < NR; p++) begin
        s_addr[p] = AW'($urandom_range(0, 3));
        s_used[p] = ($urandom_range(0, 9) < 8);
        s_rf[p]   = $urandom;
      end
      for (int i = 0; i < NS; i++) begin
        s_fv[i]   = ($urandom_range(0, 9) < 6);
        s_fd[i]   = AW'($urandom_range(0, 3));
        s_fr[i]   = ($urandom_range(0, 9) < 7);
        s_fdat[i] = $urandom;
      end
      step();
    end

    quiet();
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
